alu_cmd_sequencer: RTL and testbench

Upstream front-end for the 8-bit ALU top.
- Accepts operation commands on a valid/ready interface and buffers them in a small synchronous FIFO.
- Issues each command to the ALU as a one-cycle start pulse with held operands, then waits for the ALU done.
- Returns the 16-bit result on a valid/ready response interface.
- Also flags illegal opcodes and hung operations (timeout).

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_cmd_fifo.sv | 62 ++++++
 rtl/alu_cmd_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command front-end.
package alu_pkg;

  // ALU opcodes as carried on the command and ALU interfaces.
  localparam logic [1:0] OP_ADDSUB = 2'b00;
  localparam logic [1:0] OP_MUL    = 2'b01;
  localparam logic [1:0] OP_DIV    = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  // Sequencer states: pick a command, pulse start, wait for done, hand back the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

  // One queued command, exactly as it sits in a FIFO slot.
  typedef struct packed {
    logic [1:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

  localparam int CMD_W = $bits(alu_cmd_t);

  // Reserved opcodes never reach the ALU.
  function automatic logic is_reserved(input logic [1:0] opcode);
    return opcode == OP_RSVD;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO holding pending ALU commands. Pointers wrap modulo DEPTH
// (a power of two); a separate occupancy count tells full from empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [CMD_W-1:0]       wr_data,
  input  logic                   pop,
  output logic [CMD_W-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // A pop frees the head slot in the same cycle, so a push alongside a pop is fine even when full.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: clocked state uses <= so every register here sees the pre-edge values of the others.
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the array is deliberately not reset; pointers and count alone decide which slots are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Front-end for the 8-bit ALU: queues commands, issues them one at a time with
// a single-cycle start pulse, waits for done (or times out) and returns the result.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_opcode,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        alu_start,
  output logic [1:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [15:0] alu_result,
  input  logic        alu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [1:0]  rsp_opcode,
  output logic        rsp_error,
  output logic        busy
);

  localparam int            CW         = $clog2(DEPTH) + 1;
  localparam int            TW         = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  seq_state_t       state;
  seq_state_t       state_next;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_rd_data;
  logic [CW-1:0]    fifo_count;
  alu_cmd_t         head;
  logic [TW-1:0]    wait_cnt;
  logic             timer_expired;

  assign head          = alu_cmd_t'(fifo_rd_data);
  assign fifo_push     = cmd_valid && cmd_ready;
  assign timer_expired = (wait_cnt == TIMER_LAST);
  // The opcode register is only reloaded on pop, so it still names the responding command.
  assign rsp_opcode    = alu_opcode;

  alu_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data ({cmd_opcode, cmd_a, cmd_b}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; done beats the timer when both land in the same WAIT cycle.
  always_comb begin
    // NOTE: defaulting to the current state first keeps every path assigned, so no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = is_reserved(head.opcode) ? RESP : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (alu_done || timer_expired) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control outputs decoded from the current state.
  always_comb begin
    cmd_ready = !fifo_full;
    fifo_pop  = (state == IDLE) && !fifo_empty;
    alu_start = (state == ISSUE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE) || (fifo_count != '0);
  end

  // Operand, timer and response registers; each changes only at the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      wait_cnt   <= '0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            alu_opcode <= head.opcode;
            alu_a      <= head.a;
            alu_b      <= head.b;
            if (is_reserved(head.opcode)) begin
              rsp_result <= '0;
              rsp_error  <= 1'b1;
            end
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (alu_done) begin
            rsp_result <= alu_result;
            rsp_error  <= 1'b0;
          end else if (timer_expired) begin
            rsp_result <= '0;
            rsp_error  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TIMER_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed timing scenarios followed by random
// traffic, all responses scored against a queue-based reference model.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int HANG    = TIMEOUT + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_opcode = '0;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic        alu_start;
  logic [1:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [15:0] alu_result = '0;
  logic        alu_done = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_opcode;
  logic        rsp_error;
  logic        busy;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_opcode(rsp_opcode), .rsp_error(rsp_error), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted command carries the number of WAIT cycles the ALU model takes
  // before raising done (0 = first WAIT cycle); latencies >= TIMEOUT mean a hang.
  typedef struct {
    alu_cmd_t cmd;
    int       lat;
  } txn_t;

  txn_t        issue_q[$];
  txn_t        rsp_q[$];
  logic [15:0] rsp_log[$];
  int          next_lat = 0;

  function automatic logic [15:0] alu_fn(input alu_cmd_t c);
    case (c.opcode)
      OP_ADDSUB: return 16'(c.a) + 16'(c.b);
      OP_MUL:    return 16'(c.a) * 16'(c.b);
      OP_DIV:    return (c.b == 8'd0) ? 16'hffff : {c.a % c.b, c.a / c.b};
      default:   return 16'h0;
    endcase
  endfunction

  function automatic logic [18:0] expect_rsp(input txn_t t);
    logic err;
    err = (t.cmd.opcode == OP_RSVD) || (t.lat >= TIMEOUT);
    return {t.cmd.opcode, err, err ? 16'h0 : alu_fn(t.cmd)};
  endfunction

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)  return $urandom_range(0, 3);
    if (r == 7) return TIMEOUT - 1;
    if (r == 8) return TIMEOUT;
    return HANG;
  endfunction

  // Mid-cycle observer: scores responses, records accepted commands, and plays the ALU.
  initial begin
    txn_t        t;
    alu_cmd_t    alu_cmd_cur;
    int          alu_lat;
    int          alu_idx;
    bit          alu_active;
    bit          alu_track;
    bit          prev_start;
    bit          hold;
    logic [18:0] held;
    alu_lat = 0; alu_idx = 0; alu_active = 0; alu_track = 0; prev_start = 0; hold = 0; held = '0;
    forever begin
      @(negedge clk);
      // response side
      if (rsp_valid && hold) check("rsp_stable", {rsp_opcode, rsp_error, rsp_result}, held);
      if (rsp_valid && rsp_ready && !rst) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          t = rsp_q.pop_front();
          check("rsp_fields", {rsp_opcode, rsp_error, rsp_result}, expect_rsp(t));
        end
        rsp_log.push_back(rsp_result);
      end
      hold = rsp_valid && !rsp_ready && !rst;
      held = {rsp_opcode, rsp_error, rsp_result};
      // command side
      if (cmd_valid && cmd_ready && !rst) begin
        t.cmd = {cmd_opcode, cmd_a, cmd_b};
        t.lat = next_lat;
        rsp_q.push_back(t);
        if (cmd_opcode != OP_RSVD) issue_q.push_back(t);
      end
      // ALU side
      alu_done = 1'b0;
      if (alu_start) begin
        check("start_pulse", 32'(prev_start), 0);
        if (issue_q.size() == 0) check("start_unexpected", 1, 0);
        else begin
          t = issue_q.pop_front();
          check("issue_cmd", {alu_opcode, alu_a, alu_b}, t.cmd);
          alu_lat = t.lat;
        end
        alu_cmd_cur = {alu_opcode, alu_a, alu_b};
        alu_active  = 1;
        alu_track   = 1;
        alu_idx     = -1;
      end else if (alu_active) begin
        alu_idx++;
        if (alu_track && alu_idx <= TIMEOUT - 1 && alu_idx <= alu_lat)
          check("operand_hold", {alu_opcode, alu_a, alu_b}, alu_cmd_cur);
        if (alu_idx == alu_lat) begin
          alu_done   = 1'b1;
          alu_result = alu_fn(alu_cmd_cur);
          alu_active = 0;
        end
      end
      prev_start = alu_start;
      if (rst) begin
        issue_q.delete();
        rsp_q.delete();
        hold      = 0;
        alu_track = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input int lat);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    next_lat   = lat;
  endtask

  task automatic wait_rsp(input string tag, input int start, input int max, output int cyc);
    cyc = start;
    while (!rsp_valid && cyc < max) begin
      tick();
      cyc++;
    end
    if (!rsp_valid) check({tag, "_no_rsp"}, 0, 1);
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || busy) && n < max) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, {30'd0, (rsp_q.size() != 0), busy}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int acc;
    int nstart;
    bit will;
    bit noisy;

    rst = 1'b1;
    tick();
    tick();
    check("rst_ctrl", {cmd_ready, rsp_valid, busy, alu_start}, 4'b1000);
    check("rst_alu_ops", {alu_opcode, alu_a, alu_b}, 0);
    check("rst_rsp", {rsp_opcode, rsp_error, rsp_result}, 0);
    rst = 1'b0;

    // Single ADD with exact cycle timing.
    drive_cmd(OP_ADDSUB, 8'h12, 8'h34, 0);
    tick(); cmd_valid = 1'b0;
    check("add_c1_start", alu_start, 0);
    tick();
    check("add_c2_start", alu_start, 1);
    check("add_c2_ops", {alu_opcode, alu_a, alu_b}, {OP_ADDSUB, 8'h12, 8'h34});
    tick();
    check("add_c3", {alu_start, rsp_valid}, 0);
    tick();
    check("add_c4_rsp", {rsp_valid, rsp_error, rsp_result}, {1'b1, 1'b0, 16'h0046});
    rsp_ready = 1'b1;
    tick();
    check("add_rsp_done", rsp_valid, 0);
    rsp_ready = 1'b0;

    // Reserved opcode: straight to an error response, no start pulse.
    drive_cmd(OP_RSVD, 8'h01, 8'h01, 0);
    tick(); cmd_valid = 1'b0;
    cyc = 1; nstart = 0;
    while (!rsp_valid && cyc < 10) begin
      nstart += int'(alu_start);
      tick();
      cyc++;
    end
    check("rsvd_cycle", cyc, 2);
    check("rsvd_no_start", nstart + int'(alu_start), 0);
    check("rsvd_rsp", {rsp_opcode, rsp_error, rsp_result}, {OP_RSVD, 1'b1, 16'h0});
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    // Timeout on a hung MUL, with an ADD queued behind it.
    drive_cmd(OP_MUL, 8'd3, 8'd5, HANG);
    tick();
    drive_cmd(OP_ADDSUB, 8'd5, 8'd6, 1);
    tick(); cmd_valid = 1'b0;
    wait_rsp("tmo", 2, 20, cyc);
    check("tmo_cycle", cyc, 11);
    check("tmo_rsp", {rsp_opcode, rsp_error, rsp_result}, {OP_MUL, 1'b1, 16'h0});
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    wait_rsp("tmo_next", 0, 10, cyc);
    check("tmo_next_rsp", {rsp_opcode, rsp_error, rsp_result}, {OP_ADDSUB, 1'b0, 16'h000b});
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    // Done in the last WAIT cycle wins over the timer; one cycle later is a timeout.
    drive_cmd(OP_DIV, 8'd100, 8'd7, TIMEOUT - 1);
    tick(); cmd_valid = 1'b0;
    wait_rsp("edge_done", 1, 20, cyc);
    check("edge_done_cycle", cyc, 11);
    check("edge_done_rsp", {rsp_opcode, rsp_error, rsp_result}, {OP_DIV, 1'b0, 16'h020e});
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    drive_cmd(OP_ADDSUB, 8'd1, 8'd2, TIMEOUT);
    tick(); cmd_valid = 1'b0;
    wait_rsp("edge_late", 1, 20, cyc);
    check("edge_late_cycle", cyc, 11);
    check("edge_late_rsp", {rsp_opcode, rsp_error, rsp_result}, {OP_ADDSUB, 1'b1, 16'h0});
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    // Backpressure: only DEPTH queued plus one in flight get accepted.
    rsp_log.delete();
    acc = 0;
    for (int c = 0; c < 14; c++) begin
      drive_cmd(OP_MUL, 8'(acc + 1), 8'd2, 0);
      will = cmd_valid && cmd_ready;
      tick();
      if (will) acc++;
    end
    check("bp_accepts", acc, 5);
    check("bp_ready_low", cmd_ready, 0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (acc == 6 && rsp_q.size() == 0 && !busy) break;
      if (acc < 6) drive_cmd(OP_MUL, 8'(acc + 1), 8'd2, 0);
      else cmd_valid = 1'b0;
      will = cmd_valid && cmd_ready;
      tick();
      if (will) acc++;
    end
    cmd_valid = 1'b0;
    check("bp_accepts_all", acc, 6);
    check("bp_rsp_count", rsp_log.size(), 6);
    for (int i = 0; i < rsp_log.size(); i++) check("bp_order", rsp_log[i], 32'(2 * (i + 1)));

    // Push on the same edge that IDLE pops the only entry.
    drive_cmd(OP_ADDSUB, 8'h20, 8'h01, 0);
    tick();
    check("pp_count_before", 32'(dut.u_fifo.count), 1);
    drive_cmd(OP_ADDSUB, 8'h30, 8'h02, 0);
    tick(); cmd_valid = 1'b0;
    check("pp_count_after", 32'(dut.u_fifo.count), 1);
    wait_drain("pp", 40);

    // Reset while in WAIT with two entries queued.
    rsp_ready = 1'b0;
    drive_cmd(OP_MUL, 8'd9, 8'd9, 5);
    tick();
    drive_cmd(OP_MUL, 8'd2, 8'd3, 0);
    tick();
    drive_cmd(OP_MUL, 8'd4, 8'd5, 0);
    tick(); cmd_valid = 1'b0;
    check("rw_queued", 32'(dut.u_fifo.count), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_after_rst", {rsp_valid, busy, cmd_ready}, 3'b001);
    noisy = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rsp_valid || busy || alu_start) noisy = 1;
    end
    check("rw_quiet", 32'(noisy), 0);
    drive_cmd(OP_ADDSUB, 8'd7, 8'd8, 2);
    tick(); cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain("rw", 40);
    check("rw_new_result", rsp_log[rsp_log.size() - 1], 16'd15);

    // Random traffic against the model.
    will = 0;
    cmd_valid = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!cmd_valid || will) begin
        if ($urandom_range(0, 2) != 0)
          drive_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), pick_lat());
        else
          cmd_valid = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      will = cmd_valid && cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain("rand", 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit in case a wait loop misbehaves.
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
